// File: rtl/clint_lite.sv
// clint_lite: core-local timer, software and external interrupt source.
// Memory-mapped mtime/mtimecmp/msip behind a single-outstanding bus port.
module clint_lite #(
  parameter logic [63:0] BASE     = 64'h0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  input  logic        ext_irq_in,
  output logic        trint,
  output logic        swint,
  output logic        exint
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [12:0] W_MSIP = 13'h0000;
  localparam logic [12:0] W_CMP  = 13'h0800;
  localparam logic [12:0] W_TIME = 13'h17FF;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [63:0]   off;
  logic          hit;
  logic          cap;
  logic          acc;
  logic          wr;
  logic [12:0]   a_word;
  logic [7:0]    a_strb;
  logic [63:0]   a_data;
  logic          sel_msip;
  logic          sel_cmp;
  logic          sel_time;
  logic [63:0]   rdata;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          msip;
  logic          sync1;
  logic          unused_ok;

  assign off       = req_addr - BASE;
  assign hit       = (off[63:16] == 48'd0);
  assign unused_ok = ^off[2:0];

  assign sel_msip = (a_word == W_MSIP);
  assign sel_cmp  = (a_word == W_CMP);
  assign sel_time = (a_word == W_TIME);
  assign wr       = acc && (a_strb != 8'd0);
  assign tick     = (pcnt == PW'(TICK_DIV - 1));

  function automatic logic [63:0] merge(
    input logic [63:0] old,
    input logic [63:0] d,
    input logic [7:0]  s
  );
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) begin
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: one access cycle per captured request
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid && hit) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: capture strobe in IDLE, access strobe in ACCESS
  always_comb begin
    cap = (state == S_IDLE) && req_valid && hit;
    acc = (state == S_ACCESS);
  end

  // Latch the request so the access works from stable values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_word <= '0;
      a_strb <= '0;
      a_data <= '0;
    end else if (cap) begin
      a_word <= off[15:3];
      a_strb <= req_strobe;
      a_data <= req_data;
    end
  end

  // Read mux over the pre-update register values
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_msip: rdata = {63'd0, msip};
      sel_cmp:  rdata = mtimecmp;
      sel_time: rdata = mtime;
      default:  rdata = '0;
    endcase
  end

  // Registered response pulse and data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_data_ok <= 1'b0;
      resp_data    <= '0;
    end else begin
      resp_data_ok <= acc;
      if (acc) resp_data <= rdata;
    end
  end

  // Prescaler: free-running 0..TICK_DIV-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PW'(1);
  end

  // mtime: bus write takes priority over the tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                mtime <= '0;
    else if (wr && sel_time)   mtime <= merge(mtime, a_data, a_strb);
    else if (tick)             mtime <= mtime + 64'd1;
  end

  // mtimecmp and msip bus writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else begin
      if (wr && sel_cmp) mtimecmp <= merge(mtimecmp, a_data, a_strb);
      if (wr && sel_msip && a_strb[0]) msip <= a_data[0];
    end
  end

  // Interrupt levels and external line synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trint <= 1'b0;
      swint <= 1'b0;
      sync1 <= 1'b0;
      exint <= 1'b0;
    end else begin
      trint <= (mtime >= mtimecmp);
      swint <= msip;
      sync1 <= ext_irq_in;
      exint <= sync1;
    end
  end

endmodule

// File: doc/clint_lite.md
# clint_lite

Core-local interrupt source that drives the CSR unit's `trint`, `swint` and `exint` inputs. Holds the 64-bit `mtime` counter, the `mtimecmp` compare register and the `msip` software-interrupt bit, all memory-mapped on the data bus as a single-outstanding responder. It also synchronises the external interrupt line. It sits beside the memory-stage data path and serves loads and stores whose address falls in its window.

## Interface
- `BASE`, 64'h0200_0000: window base; window size 64 KiB.
- `TICK_DIV`, 1: `mtime` increments once every `TICK_DIV` clocks (≥1).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `req_valid`  in  1  bus request; held high until `resp_data_ok` is seen.
- `req_addr`  in  64  byte address; bits [2:0] ignored.
- `req_strobe`  in  8  byte write enables; 0 = read.
- `req_data`  in  64  write data, byte lanes aligned to `req_strobe`.
- `resp_data_ok`  out  1  one-cycle response pulse.
- `resp_data`  out  64  read data, valid with `resp_data_ok`.
- `ext_irq_in`  in  1  asynchronous external interrupt level.
- `trint`  out  1  timer interrupt level.
- `swint`  out  1  software interrupt level.
- `exint`  out  1  synchronised external interrupt level.

## Operation
- Register map (offset = `req_addr - BASE`, word index = offset[15:3]):
  - 0x0000 `msip`: bit 0 only; other bits read 0 and ignore writes.
  - 0x4000 `mtimecmp`: 64-bit.
  - 0xBFF8 `mtime`: 64-bit.
  - Any other offset inside the window reads 0, ignores writes, and still responds.
- FSM states:
  - IDLE: on `req_valid`, capture the request and go to ACCESS.
  - ACCESS: perform the read/write. Register `resp_data_ok`=1 and `resp_data` for the next cycle. Return to IDLE.
- Writes merge per byte: each strobed byte replaces the corresponding byte of the current register value.
- Reads return the register value at the ACCESS cycle, before any same-cycle increment.
- Prescaler counts 0..`TICK_DIV-1`. On wrap, `mtime` increments by 1, wrapping modulo 2^64.
- A write to `mtime` in the same cycle as a tick wins; there is no increment that cycle. The prescaler keeps running.
- `trint` is registered: `trint` <= (`mtime` >= `mtimecmp`), unsigned compare.
- `swint` = `msip`[0], registered.
- `exint` is `ext_irq_in` passed through a 2-flop synchroniser.
- All three outputs are levels. The block never clears them itself; software clears them by writing `mtimecmp` or `msip`.

## Timing
- Reset values:
  - `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, prescaler=0.
  - `trint`=`swint`=`exint`=0, `resp_data_ok`=0, `resp_data`=0.
  - FSM in IDLE.
- Access latency:
  - Request seen in IDLE at cycle N; register effect occurs at the N+1 edge.
  - `resp_data_ok`=1 and `resp_data` valid during cycle N+2.
  - `resp_data_ok` is never high for two consecutive cycles.
- A request still held high in the cycle after `resp_data_ok` is treated as a new request. The requester drops or changes it after seeing `resp_data_ok`.
- `trint` and `swint` reflect a register update one cycle after that update. `exint` follows `ext_irq_in` after 2–3 edges.
- Back-to-back requests give at most one response every 2 cycles.
- Reset asserted mid-access:
  - All state clears immediately (asynchronous); the in-flight write is lost.
  - `resp_data_ok` is 0 from assertion; no response is ever issued for that request.

## Test plan
- Reset: deassert `reset`, wait 3 cycles → all outputs 0. Read of `mtimecmp` returns all-ones; read of `msip` returns 0.
- Timer fires:
  - `TICK_DIV`=1. Write `mtimecmp`=20 (strobe 8'hFF), then read `mtime` repeatedly.
  - `trint` rises exactly one cycle after `mtime` reaches 20.
  - Writing `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF then drops `trint` one cycle after the write.
- Software interrupt: write 64'hFFFF_FFFF to `msip` → `swint`=1 and read returns 1. Write 0 → `swint`=0.
- Partial write and precedence:
  - Write `mtime` with strobe 8'h0F, data 64'h1234_5678 → upper 32 bits keep their prior value (0).
  - Hold the tick coincident with the write → no extra increment that cycle.
- Bus edges:
  - Read offset 0x1000 → data 0, `resp_data_ok` 2 cycles after the request.
  - Hold `req_valid` high continuously → responses every 2nd cycle.
- Reset mid-access: assert `reset` in the ACCESS cycle of an `mtimecmp` write → no `resp_data_ok`, and `mtimecmp` reads all-ones after release.
